// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped countdown timer.
// - FSM state encoding, register offsets (Addr[3:2]), CTRL bit positions, mode codes.
package timer_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  // Register offsets, word index taken from Addr[3:2]
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  // Mode codes; anything other than PERIODIC behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  function automatic logic is_periodic(input logic [1:0] mode);
    return mode == MODE_PERIODIC;
  endfunction

endpackage

// File: rtl/timer_dev_if.sv
// Bridge-side bus of the timer device.
// - Addr : bridge address (only [3:2] decoded by the device)
// - WE   : write enable, already qualified by the bridge hit
// - Din  : write data
// - Dout : combinational read data back to the bridge
// Modports: master (bridge side), slave (device side).
interface timer_dev_if #(
  parameter int unsigned DW = 32
);
  logic [31:0]   Addr;
  logic          WE;
  logic [DW-1:0] Din;
  logic [DW-1:0] Dout;

  modport master (output Addr, output WE, output Din, input Dout);
  modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer (DEV0 behind the system bridge).
// Ports:
// - clk   : system clock, rising edge
// - reset : asynchronous active-low reset
// - bus   : bridge bus (Addr/WE/Din in, Dout out), slave modport
// - IRQ   : level interrupt request to CP0
// Registers: CTRL (EN, MODE, IM), PRESET, COUNT (read-only); offset 3 reserved.
// Modes: one-shot (sticky pending until CTRL/PRESET write) and periodic (one-cycle pulse).
module timer_dev
  import timer_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic         clk,
  input  logic         reset,
  timer_dev_if.slave   bus,
  output logic         IRQ
);

  localparam logic [DW-1:0] LP_ONE = DW'(1);

  logic [3:0]    r_ctrl;
  logic [DW-1:0] r_preset;
  logic [DW-1:0] r_count;
  logic [1:0]    r_state;
  logic          r_pending;

  logic [3:0]    w_ctrl_nxt;
  logic [DW-1:0] w_preset_nxt;
  logic [DW-1:0] w_count_nxt;
  logic [1:0]    w_state_nxt;
  logic          w_pending_nxt;
  logic [1:0]    w_off;
  logic          w_wr_ctrl;
  logic          w_wr_preset;
  logic          w_en;
  logic          w_unused_addr;

  assign w_off         = bus.Addr[3:2];
  assign w_wr_ctrl     = bus.WE && (w_off == OFF_CTRL);
  assign w_wr_preset   = bus.WE && (w_off == OFF_PRESET);
  assign w_en          = r_ctrl[CTRL_EN];
  assign w_unused_addr = ^{bus.Addr[31:4], bus.Addr[1:0]};

  always_comb begin
    w_ctrl_nxt    = r_ctrl;
    w_preset_nxt  = r_preset;
    w_count_nxt   = r_count;
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;

    if (w_wr_ctrl)   w_ctrl_nxt   = bus.Din[3:0];
    if (w_wr_preset) w_preset_nxt = bus.Din;
    if (w_wr_ctrl || w_wr_preset) w_pending_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_en) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!w_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count > LP_ONE) begin
          w_count_nxt = r_count - LP_ONE;
        end else begin
          // PRESET=0 lands here too, so it behaves as PRESET=1
          w_count_nxt = '0;
          w_state_nxt = ST_INT;
        end
      end
      default: begin  // ST_INT; mode is the one held before any same-edge write
        if (is_periodic(r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO])) begin
          w_state_nxt = ST_LOAD;
        end else begin
          // A concurrent software CTRL write takes precedence over the auto-clear
          if (!w_wr_ctrl) w_ctrl_nxt[CTRL_EN] = 1'b0;
          w_pending_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl    <= '0;
      r_preset  <= '0;
      r_count   <= '0;
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_nxt;
      r_preset  <= w_preset_nxt;
      r_count   <= w_count_nxt;
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_comb begin
    case (w_off)
      OFF_CTRL:   bus.Dout = {{(DW-4){1'b0}}, r_ctrl};
      OFF_PRESET: bus.Dout = r_preset;
      OFF_COUNT:  bus.Dout = r_count;
      default:    bus.Dout = '0;
    endcase
  end

  assign IRQ = r_ctrl[CTRL_IM] & (r_pending | (r_state == ST_INT));

endmodule

// File: tb/tb_timer_dev.sv
module tb_timer_dev;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;

  logic clk;
  logic reset;
  logic IRQ;
  int   checks;
  int   failures;

  timer_dev_if #(.DW(32)) bus ();

  timer_dev #(.DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write lands on the next rising edge; returns 1 time unit after it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.Addr = a;
    bus.Din  = d;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE   = 1'b0;
    bus.Addr = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.Addr = a;
    #1;
    d = bus.Dout;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    logic [31:0] addrs [4];
    addrs = '{A_CTRL, A_PRESET, A_COUNT, A_RSVD};
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i], v);
      checks++;
      if (v !== 32'h0) begin
        failures++;
        $display("FAIL reset_read off=%0d got=%h exp=0", i, v);
      end
    end
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b exp=0", IRQ);
    end
  endtask

  task automatic test_oneshot;
    logic [31:0] v;
    logic        exp;
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      exp = (i == 7);
      checks++;
      if (IRQ !== exp) begin
        failures++;
        $display("FAIL oneshot_irq cycle=%0d got=%b exp=%b", i, IRQ, exp);
      end
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (IRQ !== 1'b1) begin
        failures++;
        $display("FAIL oneshot_sticky got=%b exp=1", IRQ);
      end
    end
    rd(A_CTRL, v);
    checks++;
    if (v !== 32'h8) begin
      failures++;
      $display("FAIL oneshot_ctrl got=%h exp=8", v);
    end
    rd(A_COUNT, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL oneshot_count got=%h exp=0", v);
    end
    wr(A_CTRL, 32'h8);
    @(negedge clk);
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_ack got=%b exp=0", IRQ);
    end
  endtask

  task automatic test_preset_zero;
    logic [31:0] v;
    logic        exp;
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h9);
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      exp = (i == 3);
      checks++;
      if (IRQ !== exp) begin
        failures++;
        $display("FAIL preset0_irq cycle=%0d got=%b exp=%b", i, IRQ, exp);
      end
    end
    wr(A_CTRL, 32'h8);
    @(negedge clk);
    rd(A_COUNT, v);
    checks++;
    if (v !== 32'h0 || IRQ !== 1'b0) begin
      failures++;
      $display("FAIL preset0_end count=%h irq=%b exp count=0 irq=0", v, IRQ);
    end
  endtask

  task automatic test_periodic;
    logic exp;
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'hB);
    for (int i = 0; i <= 15; i++) begin
      @(negedge clk);
      exp = (i > 0) && (i % 5 == 0);
      checks++;
      if (IRQ !== exp) begin
        failures++;
        $display("FAIL periodic_irq cycle=%0d got=%b exp=%b", i, IRQ, exp);
      end
    end
    wr(A_CTRL, 32'h0);
    repeat (8) @(negedge clk);
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("FAIL periodic_stop got=%b exp=0", IRQ);
    end
  endtask

  task automatic test_mask;
    logic [31:0] v;
    int          hits;
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h1);
    hits = 0;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (IRQ !== 1'b0) hits++;
    end
    checks++;
    if (hits != 0) begin
      failures++;
      $display("FAIL mask_irq high_cycles=%0d exp=0", hits);
    end
    rd(A_CTRL, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL mask_ctrl got=%h exp=0", v);
    end
    rd(A_COUNT, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL mask_count got=%h exp=0", v);
    end
    wr(A_CTRL, 32'h8);
    @(negedge clk);
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("FAIL mask_unmask got=%b exp=0", IRQ);
    end
  endtask

  task automatic test_disable;
    logic [31:0] v;
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    repeat (3) @(posedge clk);
    wr(A_CTRL, 32'h8);
    repeat (5) @(negedge clk);
    rd(A_COUNT, v);
    checks++;
    if (v !== 32'd8) begin
      failures++;
      $display("FAIL disable_count got=%0d exp=8", v);
    end
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("FAIL disable_irq got=%b exp=0", IRQ);
    end
    wr(A_COUNT, 32'h55);
    wr(A_RSVD, 32'hAA);
    @(negedge clk);
    rd(A_COUNT, v);
    checks++;
    if (v !== 32'd8) begin
      failures++;
      $display("FAIL ro_count got=%0d exp=8", v);
    end
    rd(A_RSVD, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL ro_rsvd got=%h exp=0", v);
    end
    rd(A_CTRL, v);
    checks++;
    if (v !== 32'h8) begin
      failures++;
      $display("FAIL ro_ctrl got=%h exp=8", v);
    end
    rd(A_PRESET, v);
    checks++;
    if (v !== 32'd10) begin
      failures++;
      $display("FAIL ro_preset got=%0d exp=10", v);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] v;
    logic [31:0] addrs [4];
    int          hits;
    addrs = '{A_CTRL, A_PRESET, A_COUNT, A_RSVD};
    wr(A_PRESET, 32'd100);
    wr(A_CTRL, 32'h9);
    repeat (20) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i], v);
      checks++;
      if (v !== 32'h0) begin
        failures++;
        $display("FAIL async_reset off=%0d got=%h exp=0", i, v);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (IRQ !== 1'b0) hits++;
    end
    checks++;
    if (hits != 0) begin
      failures++;
      $display("FAIL async_post_irq high_cycles=%0d exp=0", hits);
    end
    rd(A_COUNT, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL async_post_count got=%h exp=0", v);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.Addr = 32'h0;
    bus.WE   = 1'b0;
    bus.Din  = 32'h0;
    test_reset();
    test_oneshot();
    test_preset_zero();
    test_periodic();
    test_mask();
    test_disable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
